// File: rtl/register_file_32x32.sv
// Two-read, one-write register file with registered read ports and a read-valid strobe.
// Reads sample pre-write contents; optional hardwired-zero register 0.
module register_file_32x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          R0_ZERO    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d [NumRegs];
  logic [NumRegs-1:0]    wr_en;

  logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d;
  logic [DATA_WIDTH-1:0] data_r2_q, data_r2_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd1_word, rd2_word;

  // One-hot write decode; register 0 never loads in the hardwired-zero build.
  always_comb begin
    wr_en = '0;
    if (WRITE) begin
      wr_en[ADDR_W] = 1'b1;
    end
    if (R0_ZERO) begin
      wr_en[0] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = wr_en[i] ? DATA_W : regs_q[i];
    end
  end

  always_comb begin
    rd1_word = regs_q[ADDR_R1];
    rd2_word = regs_q[ADDR_R2];
    if (R0_ZERO && (ADDR_R1 == '0)) begin
      rd1_word = '0;
    end
    if (R0_ZERO && (ADDR_R2 == '0)) begin
      rd2_word = '0;
    end
  end

  // Reads take regs_q (pre-write), so a same-edge write is not bypassed.
  always_comb begin
    data_r1_d  = READ ? rd1_word : data_r1_q;
    data_r2_d  = READ ? rd2_word : data_r2_q;
    rd_valid_d = READ;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      data_r1_q  <= '0;
      data_r2_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
      data_r1_q  <= data_r1_d;
      data_r2_q  <= data_r2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign DATA_R1  = data_r1_q;
  assign DATA_R2  = data_r2_q;
  assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench: two DUTs (R0_ZERO=0 and R0_ZERO=1) share stimulus and are
// compared every cycle against an array-based reference model.
module tb_register_file_32x32;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] ar1   = '0;
  logic [AW-1:0] ar2   = '0;
  logic [AW-1:0] aw    = '0;
  logic [DW-1:0] dw    = '0;

  logic [DW-1:0] r1_a, r2_a, r1_b, r2_b;
  logic          v_a, v_b;

  int tests  = 0;
  int failed = 0;

  // Reference state: a = ordinary register 0, b = hardwired-zero register 0.
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [DW-1:0] e1_a, e2_a, e1_b, e2_b;
  logic          ev;

  register_file_32x32 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .R0_ZERO(1'b0)) u_dut_a (
    .CLK(clk), .RESET(rst_n), .READ(rd), .WRITE(wr),
    .ADDR_R1(ar1), .ADDR_R2(ar2), .ADDR_W(aw), .DATA_W(dw),
    .DATA_R1(r1_a), .DATA_R2(r2_a), .RD_VALID(v_a)
  );

  register_file_32x32 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .R0_ZERO(1'b1)) u_dut_b (
    .CLK(clk), .RESET(rst_n), .READ(rd), .WRITE(wr),
    .ADDR_R1(ar1), .ADDR_R2(ar2), .ADDR_W(aw), .DATA_W(dw),
    .DATA_R1(r1_b), .DATA_R2(r2_b), .RD_VALID(v_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    e1_a = '0; e2_a = '0; e1_b = '0; e2_b = '0; ev = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a_r1"}, r1_a, e1_a);
    check({tag, "_a_r2"}, r2_a, e2_a);
    check({tag, "_a_vld"}, {31'b0, v_a}, {31'b0, ev});
    check({tag, "_b_r1"}, r1_b, e1_b);
    check({tag, "_b_r2"}, r2_b, e2_b);
    check({tag, "_b_vld"}, {31'b0, v_b}, {31'b0, ev});
  endtask

  // One clock: model reads old contents, then applies the write; outputs checked 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rd) begin
      e1_a = mem_a[ar1];
      e2_a = mem_a[ar2];
      e1_b = (ar1 == 0) ? '0 : mem_b[ar1];
      e2_b = (ar2 == 0) ? '0 : mem_b[ar2];
    end
    ev = rd;
    if (wr) begin
      mem_a[aw] = dw;
      if (aw != 0) mem_b[aw] = dw;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_op(input string tag, input logic r, input logic w, input int a1,
                       input int a2, input int awv, input logic [DW-1:0] d);
    rd = r; wr = w; ar1 = AW'(a1); ar2 = AW'(a2); aw = AW'(awv); dw = d;
    cycle(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle clears outputs and storage without an edge.
    do_op("wr_r5", 1'b0, 1'b1, 0, 0, 5, 32'hDEADBEEF);
    do_op("rd_r5", 1'b1, 1'b0, 5, 5, 0, '0);
    check("rd_r5_lit", r1_a, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("rd_r5_post", 1'b1, 1'b0, 5, 5, 0, '0);
    check("rd_r5_post_lit", r1_a, 32'h0);

    // Write/read sweep, back-to-back reads.
    for (int i = 0; i < N; i++) do_op("sweep_wr", 1'b0, 1'b1, 0, 0, i, DW'(i) * 32'h01010101);
    for (int i = 0; i < N; i++) do_op("sweep_rd", 1'b1, 1'b0, i, N - 1 - i, 0, '0);
    check("sweep_last_r1", r1_a, 32'h1F1F1F1F);
    check("sweep_last_r2b", r2_b, 32'h0);

    // Same-edge read and write returns old data.
    do_op("col_pre", 1'b0, 1'b1, 0, 0, 7, 32'h11111111);
    do_op("col", 1'b1, 1'b1, 7, 7, 7, 32'h22222222);
    check("col_old", r1_a, 32'h11111111);
    do_op("col_new", 1'b1, 1'b0, 7, 7, 0, '0);
    check("col_new_lit", r1_a, 32'h22222222);

    // Hold while idle, even across writes to the held address.
    do_op("hold_wr", 1'b0, 1'b1, 0, 0, 3, 32'hA5A5A5A5);
    do_op("hold_rd", 1'b1, 1'b0, 3, 3, 0, '0);
    for (int i = 0; i < 4; i++) begin
      do_op("hold_idle", 1'b0, 1'b1, 3, 3, 3, 32'h5A5A5A5A);
      check("hold_lit", r1_a, 32'hA5A5A5A5);
    end

    // Register 0 behaviour in both builds.
    do_op("r0_wr0", 1'b0, 1'b1, 0, 0, 0, 32'hFFFFFFFF);
    do_op("r0_wr1", 1'b0, 1'b1, 0, 0, 1, 32'hFFFFFFFF);
    do_op("r0_rd", 1'b1, 1'b0, 0, 1, 0, '0);
    check("r0_a_lit", r1_a, 32'hFFFFFFFF);
    check("r0_b_lit", r1_b, 32'h0);
    check("r1_b_lit", r2_b, 32'hFFFFFFFF);

    // Isolation: a single written register, everything else reads zero.
    pulse_reset();
    do_op("iso_wr", 1'b0, 1'b1, 0, 0, 10, 32'h12345678);
    for (int i = 0; i < N; i++) begin
      if (i != 10) begin
        do_op("iso_rd", 1'b1, 1'b0, i, i, 0, '0);
        check("iso_zero", r1_a, 32'h0);
      end
    end
    do_op("iso_nowr", 1'b0, 1'b0, 0, 0, 10, 32'h0);
    do_op("iso_rd10", 1'b1, 1'b0, 10, 10, 0, '0);
    check("iso_r10_lit", r2_a, 32'h12345678);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
            int'($urandom_range(0, N - 1)), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
